// File: rtl/std_mem_arbiter_if.sv
// std_mem_intf: generic valid/ready memory stream used for commands and results.
//   valid        : payload is valid (driven by master)
//   ready        : sink can accept this cycle (driven by slave)
//   read_enable  : read command / read result
//   write_enable : write command / write result
//   addr         : address
//   data         : write data (command) or read data (result)
interface std_mem_intf #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic                  read_enable;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    modport master (
        output valid,
        output read_enable,
        output write_enable,
        output addr,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  read_enable,
        input  write_enable,
        input  addr,
        input  data,
        output ready
    );
endinterface

// File: rtl/std_mem_arbiter.sv
// std_mem_arbiter: two-requester arbiter onto one shared memory command port,
// with an in-order tag FIFO that routes each returning result to its requester.
//
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   command0      : requester 0 (instruction) command stream, slave
//   command1      : requester 1 (data) command stream, slave
//   command_out   : shared memory command port, master
//   result_in     : in-order result stream from memory, slave
//   result0/1     : results returned to requester 0/1, master
//
// Build option:
//   STD_MEM_ARBITER_FIXED_PRIORITY_EN defined   -> requester 1 always wins contention
//   STD_MEM_ARBITER_FIXED_PRIORITY_EN undefined -> round-robin contention
module std_mem_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic        clk,
    input logic        rst,
    std_mem_intf.slave  command0,
    std_mem_intf.slave  command1,
    std_mem_intf.master command_out,
    std_mem_intf.slave  result_in,
    std_mem_intf.master result0,
    std_mem_intf.master result1
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   lock_owner_q;
    logic   lock_owner_d;

    logic   grant_c;
    logic   cmd_valid_c;
    logic   cmd_accept_c;
    logic   cmd_fire_c;

    logic [ADDR_WIDTH-1:0] cmd_addr_c;
    logic [DATA_WIDTH-1:0] cmd_data_c;
    logic                  cmd_rd_c;
    logic                  cmd_wr_c;

    logic             tag_mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_full_c;
    logic             fifo_empty_c;
    logic             head_tag_c;
    logic             res_route_c;
    logic             res_fire_c;

`ifndef STD_MEM_ARBITER_FIXED_PRIORITY_EN
    logic last_grant_q;
`endif

    // Grant selection: a held lock wins, otherwise single requester or contention rule
    always_comb begin : grant_select
        grant_c = 1'b0;
        if (state_q == ST_LOCKED) begin
            grant_c = lock_owner_q;
        end else if (command0.valid && command1.valid) begin
`ifdef STD_MEM_ARBITER_FIXED_PRIORITY_EN
            grant_c = 1'b1;
`else
            grant_c = ~last_grant_q;
`endif
        end else if (command1.valid) begin
            grant_c = 1'b1;
        end
    end

    // Command handshake; registered full blocks acceptance even on a pop cycle
    assign cmd_valid_c  = !rst && (grant_c ? command1.valid : command0.valid);
    assign cmd_accept_c = !rst && command_out.ready && !fifo_full_c;
    assign cmd_fire_c   = cmd_valid_c && cmd_accept_c;

    // Ready only to the granted, valid requester so idle ports read ready = 0
    assign command0.ready = cmd_fire_c && !grant_c;
    assign command1.ready = cmd_fire_c &&  grant_c;

    // Combinational payload forwarding from the granted requester
    always_comb begin : cmd_payload_mux
        cmd_addr_c = command0.addr;
        cmd_data_c = command0.data;
        cmd_rd_c   = command0.read_enable;
        cmd_wr_c   = command0.write_enable;
        if (grant_c) begin
            cmd_addr_c = command1.addr;
            cmd_data_c = command1.data;
            cmd_rd_c   = command1.read_enable;
            cmd_wr_c   = command1.write_enable;
        end
    end

    assign command_out.valid        = cmd_valid_c;
    assign command_out.addr         = cmd_addr_c;
    assign command_out.data         = cmd_data_c;
    assign command_out.read_enable  = cmd_rd_c;
    assign command_out.write_enable = cmd_wr_c;

    // Arbiter state register
    always_ff @(posedge clk) begin : fsm_reg
        if (rst) begin
            state_q      <= ST_IDLE;
            lock_owner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    // Lock on a stalled offer, release on the completing cycle
    always_comb begin : fsm_next
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_c && !cmd_fire_c) begin
                    state_d      = ST_LOCKED;
                    lock_owner_d = grant_c;
                end
            end
            ST_LOCKED: begin
                if (cmd_fire_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifndef STD_MEM_ARBITER_FIXED_PRIORITY_EN
    // Round-robin history, updated only by completed command transfers
    always_ff @(posedge clk) begin : last_grant_reg
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (cmd_fire_c) begin
            last_grant_q <= grant_c;
        end
    end
`endif

    // Tag FIFO status
    assign fifo_full_c  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty_c = (count_q == CNT_W'(0));
    assign head_tag_c   = tag_mem_q[rd_ptr_q];

    // Tag FIFO storage; contents are qualified by count so need no reset
    always_ff @(posedge clk) begin : tag_store
        if (cmd_fire_c) begin
            tag_mem_q[wr_ptr_q] <= grant_c;
        end
    end

    // Tag FIFO pointers and occupancy; power-of-two depth wraps naturally
    always_ff @(posedge clk) begin : tag_ptrs
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (cmd_fire_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (res_fire_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({cmd_fire_c, res_fire_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Result routing by head tag; nothing flows while empty or in reset
    assign res_route_c     = !rst && !fifo_empty_c;
    assign result_in.ready = res_route_c && (head_tag_c ? result1.ready : result0.ready);
    assign res_fire_c      = result_in.valid && result_in.ready;

    assign result0.valid        = res_route_c && !head_tag_c && result_in.valid;
    assign result0.addr         = result_in.addr;
    assign result0.data         = result_in.data;
    assign result0.read_enable  = result_in.read_enable;
    assign result0.write_enable = result_in.write_enable;

    assign result1.valid        = res_route_c &&  head_tag_c && result_in.valid;
    assign result1.addr         = result_in.addr;
    assign result1.data         = result_in.data;
    assign result1.read_enable  = result_in.read_enable;
    assign result1.write_enable = result_in.write_enable;

endmodule

// File: tb/tb_std_mem_arbiter.sv
// tb_std_mem_arbiter: directed self-checking bench for std_mem_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge. Expectations follow STD_MEM_ARBITER_FIXED_PRIORITY_EN if defined.
module tb_std_mem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned MO = 4;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    std_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) c0_if ();
    std_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) c1_if ();
    std_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cout_if ();
    std_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rin_if ();
    std_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r0_if ();
    std_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r1_if ();

    std_mem_arbiter #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .command0    (c0_if),
        .command1    (c1_if),
        .command_out (cout_if),
        .result_in   (rin_if),
        .result0     (r0_if),
        .result1     (r1_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        c0_if.valid = 1'b0; c0_if.read_enable = 1'b1; c0_if.write_enable = 1'b0;
        c0_if.addr = '0; c0_if.data = '0;
        c1_if.valid = 1'b0; c1_if.read_enable = 1'b1; c1_if.write_enable = 1'b0;
        c1_if.addr = '0; c1_if.data = '0;
        rin_if.valid = 1'b0; rin_if.read_enable = 1'b1; rin_if.write_enable = 1'b0;
        rin_if.addr = '0; rin_if.data = '0;
        cout_if.ready = 1'b1;
        r0_if.ready = 1'b1;
        r1_if.ready = 1'b1;
    endtask

    // Outputs held low during reset and with no traffic afterwards
    task automatic test_reset();
        logic [5:0] st;
        drive_idle();
        rst = 1'b1;
        c0_if.valid = 1'b1; c0_if.addr = 32'h10;
        c1_if.valid = 1'b1; c1_if.addr = 32'h20;
        rin_if.valid = 1'b1;
        next_cycle();
        @(negedge clk);
        st = {c0_if.ready, c1_if.ready, cout_if.valid, r0_if.valid, r1_if.valid, rin_if.ready};
        n_checks++; if (st !== 6'b0) begin n_fail++; $display("FAIL reset_hold outputs got %b want %b", st, 6'b0); end
        next_cycle();
        rst = 1'b0;
        c0_if.valid = 1'b0; c1_if.valid = 1'b0;
        @(negedge clk);
        st = {c0_if.ready, c1_if.ready, cout_if.valid, r0_if.valid, r1_if.valid, rin_if.ready};
        n_checks++; if (st !== 6'b0) begin n_fail++; $display("FAIL post_reset outputs got %b want %b", st, 6'b0); end
        next_cycle();
        rin_if.valid = 1'b0;
    endtask

    // Single requester 1 command then its result routed to result1
    task automatic test_single();
        c1_if.valid = 1'b1; c1_if.addr = 32'h20; c1_if.data = 32'h55;
        @(negedge clk);
        n_checks++; if ({cout_if.valid, c0_if.ready, c1_if.ready} !== 3'b101) begin n_fail++; $display("FAIL single_grant got %b want %b", {cout_if.valid, c0_if.ready, c1_if.ready}, 3'b101); end
        n_checks++; if ({cout_if.addr, cout_if.data} !== {32'h20, 32'h55}) begin n_fail++; $display("FAIL single_payload got %h want %h", {cout_if.addr, cout_if.data}, {32'h20, 32'h55}); end
        next_cycle();
        c1_if.valid = 1'b0;
        rin_if.valid = 1'b1; rin_if.addr = 32'h20; rin_if.data = 32'hAA;
        @(negedge clk);
        n_checks++; if ({r0_if.valid, r1_if.valid, rin_if.ready} !== 3'b011) begin n_fail++; $display("FAIL single_route got %b want %b", {r0_if.valid, r1_if.valid, rin_if.ready}, 3'b011); end
        n_checks++; if (r1_if.data !== 32'hAA) begin n_fail++; $display("FAIL single_rdata got %h want %h", r1_if.data, 32'hAA); end
        next_cycle();
        @(negedge clk);
        n_checks++; if ({r0_if.valid, r1_if.valid, rin_if.ready} !== 3'b000) begin n_fail++; $display("FAIL empty_stall got %b want %b", {r0_if.valid, r1_if.valid, rin_if.ready}, 3'b000); end
        next_cycle();
        rin_if.valid = 1'b0;
    endtask

    // Both requesters valid for 8 cycles; results return 2 cycles after issue
    task automatic test_contention();
        logic [31:0] q_addr[$];
        int          q_due[$];
        for (int cyc = 0; cyc < 14; cyc++) begin
            logic        active;
            logic        exp_g;
            logic        res_now;
            logic [31:0] exp_a;
            logic [31:0] res_a;
            active = (cyc < 8);
            c0_if.valid = active; c0_if.addr = 32'h10;
            c1_if.valid = active; c1_if.addr = 32'h20;
            res_now = (q_due.size() > 0) && (q_due[0] <= cyc);
            res_a   = res_now ? q_addr[0] : 32'h0;
            rin_if.valid = res_now; rin_if.addr = res_a; rin_if.data = res_a;
            @(negedge clk);
            if (active) begin
`ifdef STD_MEM_ARBITER_FIXED_PRIORITY_EN
                exp_g = 1'b1;
`else
                exp_g = ((cyc % 2) == 1);
`endif
                exp_a = exp_g ? 32'h20 : 32'h10;
                n_checks++; if ({c0_if.ready, c1_if.ready} !== {~exp_g, exp_g}) begin n_fail++; $display("FAIL contention_grant cyc %0d got %b want %b", cyc, {c0_if.ready, c1_if.ready}, {~exp_g, exp_g}); end
                n_checks++; if (cout_if.addr !== exp_a) begin n_fail++; $display("FAIL contention_addr cyc %0d got %h want %h", cyc, cout_if.addr, exp_a); end
                q_addr.push_back(exp_a);
                q_due.push_back(cyc + 2);
            end
            if (res_now) begin
                n_checks++; if ({r0_if.valid, r1_if.valid, rin_if.ready} !== {res_a == 32'h10, res_a == 32'h20, 1'b1}) begin n_fail++; $display("FAIL contention_route cyc %0d got %b for addr %h", cyc, {r0_if.valid, r1_if.valid, rin_if.ready}, res_a); end
                n_checks++; if (((res_a == 32'h10) ? r0_if.data : r1_if.data) !== res_a) begin n_fail++; $display("FAIL contention_rdata cyc %0d got %h want %h", cyc, ((res_a == 32'h10) ? r0_if.data : r1_if.data), res_a); end
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            next_cycle();
        end
        rin_if.valid = 1'b0;
        n_checks++; if (q_due.size() !== 0) begin n_fail++; $display("FAIL contention_drain left %0d want 0", q_due.size()); end
    endtask

    // Grant to requester 0 held while memory stalls 3 cycles
    task automatic test_lock();
        cout_if.ready = 1'b0;
        c0_if.valid = 1'b1; c0_if.addr = 32'h30;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin c1_if.valid = 1'b1; c1_if.addr = 32'h40; end
            @(negedge clk);
            n_checks++; if ({cout_if.valid, c0_if.ready, c1_if.ready} !== 3'b100) begin n_fail++; $display("FAIL lock_hold cyc %0d got %b want %b", i, {cout_if.valid, c0_if.ready, c1_if.ready}, 3'b100); end
            n_checks++; if (cout_if.addr !== 32'h30) begin n_fail++; $display("FAIL lock_addr cyc %0d got %h want %h", i, cout_if.addr, 32'h30); end
            next_cycle();
        end
        cout_if.ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({c0_if.ready, c1_if.ready, cout_if.addr} !== {2'b10, 32'h30}) begin n_fail++; $display("FAIL lock_release got %h want %h", {c0_if.ready, c1_if.ready, cout_if.addr}, {2'b10, 32'h30}); end
        next_cycle();
        c0_if.valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({c0_if.ready, c1_if.ready, cout_if.addr} !== {2'b01, 32'h40}) begin n_fail++; $display("FAIL lock_next got %h want %h", {c0_if.ready, c1_if.ready, cout_if.addr}, {2'b01, 32'h40}); end
        next_cycle();
        c1_if.valid = 1'b0;
    endtask

    // FIFO holds tags [0,1]; result1 stalls while head tag is 1
    task automatic test_backpressure();
        rin_if.valid = 1'b1; rin_if.data = 32'h300;
        r0_if.ready = 1'b1; r1_if.ready = 1'b0;
        @(negedge clk);
        n_checks++; if ({r0_if.valid, r1_if.valid, rin_if.ready} !== 3'b101) begin n_fail++; $display("FAIL bp_head0 got %b want %b", {r0_if.valid, r1_if.valid, rin_if.ready}, 3'b101); end
        next_cycle();
        rin_if.data = 32'h400;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if ({r0_if.valid, r1_if.valid, rin_if.ready} !== 3'b010) begin n_fail++; $display("FAIL bp_stall cyc %0d got %b want %b", i, {r0_if.valid, r1_if.valid, rin_if.ready}, 3'b010); end
            next_cycle();
        end
        r1_if.ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({r0_if.valid, r1_if.valid, rin_if.ready, r1_if.data} !== {3'b011, 32'h400}) begin n_fail++; $display("FAIL bp_release got %h want %h", {r0_if.valid, r1_if.valid, rin_if.ready, r1_if.data}, {3'b011, 32'h400}); end
        next_cycle();
        @(negedge clk);
        n_checks++; if ({r0_if.valid, r1_if.valid, rin_if.ready} !== 3'b000) begin n_fail++; $display("FAIL bp_empty got %b want %b", {r0_if.valid, r1_if.valid, rin_if.ready}, 3'b000); end
        next_cycle();
        rin_if.valid = 1'b0;
    endtask

    // Four accepted, fifth stalls until one result pops (not on the pop cycle)
    task automatic test_full();
        c0_if.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c0_if.addr = 32'h50 + 32'(i);
            @(negedge clk);
            n_checks++; if (c0_if.ready !== 1'b1) begin n_fail++; $display("FAIL full_fill %0d got %b want %b", i, c0_if.ready, 1'b1); end
            next_cycle();
        end
        c0_if.addr = 32'h54;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if ({cout_if.valid, c0_if.ready} !== 2'b10) begin n_fail++; $display("FAIL full_stall %0d got %b want %b", i, {cout_if.valid, c0_if.ready}, 2'b10); end
            next_cycle();
        end
        rin_if.valid = 1'b1; rin_if.data = 32'h500; r0_if.ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({c0_if.ready, rin_if.ready, r0_if.valid} !== 3'b011) begin n_fail++; $display("FAIL full_pop_cycle got %b want %b", {c0_if.ready, rin_if.ready, r0_if.valid}, 3'b011); end
        next_cycle();
        rin_if.valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({c0_if.ready, cout_if.addr} !== {1'b1, 32'h54}) begin n_fail++; $display("FAIL full_accept got %h want %h", {c0_if.ready, cout_if.addr}, {1'b1, 32'h54}); end
        next_cycle();
        c0_if.valid = 1'b0;
    endtask

    // FIFO holds 4; pop one, lock requester 1, then pulse reset
    task automatic test_reset_mid();
        logic [5:0] st;
        rin_if.valid = 1'b1; r0_if.ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rin_if.ready !== 1'b1) begin n_fail++; $display("FAIL rm_pop got %b want %b", rin_if.ready, 1'b1); end
        next_cycle();
        rin_if.valid = 1'b0;
        cout_if.ready = 1'b0;
        c1_if.valid = 1'b1; c1_if.addr = 32'h60;
        @(negedge clk);
        n_checks++; if ({cout_if.valid, c1_if.ready, cout_if.addr} !== {2'b10, 32'h60}) begin n_fail++; $display("FAIL rm_lock got %h want %h", {cout_if.valid, c1_if.ready, cout_if.addr}, {2'b10, 32'h60}); end
        next_cycle();
        rst = 1'b1;
        cout_if.ready = 1'b1;
        c0_if.valid = 1'b1; c0_if.addr = 32'h70;
        rin_if.valid = 1'b1;
        @(negedge clk);
        st = {c0_if.ready, c1_if.ready, cout_if.valid, r0_if.valid, r1_if.valid, rin_if.ready};
        n_checks++; if (st !== 6'b0) begin n_fail++; $display("FAIL rm_during got %b want %b", st, 6'b0); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({r0_if.valid, r1_if.valid, rin_if.ready} !== 3'b000) begin n_fail++; $display("FAIL rm_fifo_empty got %b want %b", {r0_if.valid, r1_if.valid, rin_if.ready}, 3'b000); end
`ifdef STD_MEM_ARBITER_FIXED_PRIORITY_EN
        n_checks++; if ({c0_if.ready, c1_if.ready, cout_if.addr} !== {2'b01, 32'h60}) begin n_fail++; $display("FAIL rm_next_grant got %h want %h", {c0_if.ready, c1_if.ready, cout_if.addr}, {2'b01, 32'h60}); end
`else
        n_checks++; if ({c0_if.ready, c1_if.ready, cout_if.addr} !== {2'b10, 32'h70}) begin n_fail++; $display("FAIL rm_next_grant got %h want %h", {c0_if.ready, c1_if.ready, cout_if.addr}, {2'b10, 32'h70}); end
`endif
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_backpressure();
        test_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
